scan_controller: RTL
====================

// Module: scan_controller
// PURPOSE
//  Time-multiplexing scheduler for the 4-digit 7-segment display. It decides which
//  digit owns the shared segment bus in each slot and drives the active-low anodes.
//  Each slot has inter-digit blanking and PWM brightness. Digits whose mask bit is 0
//  are skipped and consume no slot time.
//  Sits between the board clock and the segment decoder. digit_sel selects the
//  nibble for the decoder; an drives the board anodes directly.
// PARAMETERS
//  SLOT_CYCLES   18  clk cycles per digit slot (blank + lit + dark); SLOT-BLANK >= 16
//  BLANK_CYCLES   2  leading cycles of every slot with all anodes off (ghosting guard)
// PORTS
//  clk          in   1  board clock
//  reset_n      in   1  synchronous, active-low reset
//  enable       in   1  1 = scan; 0 = display dark, scheduler idle
//  digit_mask   in   4  bit i = 1 -> digit i takes part in the scan
//  brightness   in   4  lit cycles per slot, 0 (dark) .. 15
//  an           out  4  anodes, active-low, one-hot-low or 4'hF
//  digit_sel    out  2  index of the digit owning the current slot
//  blank        out  1  1 whenever an == 4'hF
//  frame_done   out  1  one-cycle pulse on the last cycle of the last enabled digit's slot
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state IDLE, an=4'hF, digit_sel=0, blank=1, frame_done=0.
//   Reset overrides all other inputs, including in mid-slot.
//  All outputs are registered. W = SLOT_CYCLES-BLANK_CYCLES (default 16).
//  FSM states: IDLE, BLANK, ON, OFF; slot counter; registered copies of mask and brightness.
//  IDLE: an=F. When enable=1 and digit_mask!=0 at an edge, the next cycle is BLANK.
//   That slot belongs to the lowest-index set mask bit.
//  Slot start (entry to BLANK): sample digit_mask and brightness, and set digit_sel.
//   Input changes during a slot take effect only at the next slot boundary.
//  BLANK: BLANK_CYCLES cycles, an=F, digit_sel already valid so the decoder settles.
//  ON: brightness cycles, an[digit_sel]=0 and all other bits 1. Skipped if brightness=0.
//  OFF: W-brightness cycles, an=F. Never skipped, because W >= 16 > 15.
//  Slot length is always exactly SLOT_CYCLES, independent of brightness.
//  Next digit: the next set bit of the sampled mask above digit_sel, wrapping 3->0.
//   A single enabled digit re-selects itself every slot.
//  frame_done: high for the final OFF cycle of the slot of the highest enabled digit.
//   Frame period = popcount(mask)*SLOT_CYCLES.
//  Slot end with enable=0 or a freshly sampled mask=0: go to IDLE.
//   The current slot always completes; no frame_done pulse is generated in that case.
//  enable dropping mid-slot: the slot completes normally and an is never cut short.
//   Only reset truncates a slot.
//  Counter widths are sized from SLOT_CYCLES with $clog2. There is no arithmetic
//   overflow, because brightness <= 15 < W.
// TESTING
//  T1 reset: reset_n=0 for 3 cycles with enable=1, mask=F -> an=F, digit_sel=0,
//     blank=1, frame_done=0 every cycle.
//  T2 full scan, mask=F, bright=15: per slot 2 cycles F, 15 cycles 1110/1101/1011/0111,
//     then 1 cycle F. frame_done every 72 cycles, on the last cycle of the digit-3 slot.
//  T3 sparse mask=0101, bright=8: slots alternate digit 0 and digit 2 (an 1110 / 1011).
//     Each slot: 8 lit + 8 dark; frame_done period 36 cycles.
//  T4 bright=0, mask=F: an stays F, blank=1 throughout; digit_sel still rotates 0..3
//     every 18 cycles and frame_done still pulses every 72 cycles.
//  T5 mid-slot changes: set bright 15->3 and mask F->0010 in the 5th cycle of the
//     digit-0 slot -> that slot stays 15 lit; the next slot is digit 1 with 3 lit.
//     Then set mask=0 -> the slot completes, then IDLE with an=F.
//  T6 reset during ON (cycle 6 of slot) -> the next cycle an=F, digit_sel=0, state IDLE.
//     After reset release with enable=1, BLANK starts one cycle later.

Source files
------------

// File: rtl/scan_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_controller : 4-digit 7-segment time-multiplex scheduler with PWM
// Rev 1.0
// ---------------------------------------------------------------------------
module scan_controller #(
    parameter int SLOT_CYCLES  = 18,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] digit_mask,
    input  logic [3:0] brightness,
    output logic [3:0] an,
    output logic [1:0] digit_sel,
    output logic       blank,
    output logic       frame_done
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2,
        OFF   = 2'd3
    } state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [3:0]    mask_q, nmask;
    logic [3:0]    bright_q, nbright;
    logic [1:0]    nsel;
    logic          nfd;
    logic          slot_start;
    logic          keep_going;

    // First set bit of m strictly after 'from', wrapping 3->0 (may return 'from')
    function automatic logic [1:0] next_digit(input logic [3:0] m, input logic [1:0] from);
        logic [1:0] r;
        logic [1:0] idx;
        r = from;
        for (int i = 4; i >= 1; i--) begin
            idx = 2'(int'(from) + i);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    function automatic logic [1:0] top_digit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    always_comb begin
        nstate     = state;
        ncnt       = cnt;
        nmask      = mask_q;
        nbright    = bright_q;
        nsel       = digit_sel;
        nfd        = 1'b0;
        slot_start = 1'b0;
        keep_going = enable && (digit_mask != 4'd0);

        if (state == IDLE) begin
            slot_start = keep_going;
        end else if (cnt == LAST_CNT) begin
            if (keep_going) slot_start = 1'b1;
            else            nstate     = IDLE;
            ncnt = '0;
        end else begin
            ncnt = cnt + 1'b1;
            if (ncnt < BLANK_CNT)                        nstate = BLANK;
            else if (ncnt < BLANK_CNT + CW'(bright_q))   nstate = ON;
            else                                         nstate = OFF;
        end

        if (slot_start) begin
            nstate  = BLANK;
            ncnt    = '0;
            nmask   = digit_mask;
            nbright = brightness;
            // From IDLE the search starts after digit 3, i.e. at the lowest set bit
            nsel    = next_digit(digit_mask, (state == IDLE) ? 2'd3 : digit_sel);
        end

        // Suppress the pulse when the frame is about to stop at this slot's end
        nfd = (nstate != IDLE) && (ncnt == LAST_CNT) && (nsel == top_digit(nmask)) && keep_going;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mask_q     <= 4'd0;
            bright_q   <= 4'd0;
            digit_sel  <= 2'd0;
            an         <= 4'hF;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= nstate;
            cnt        <= ncnt;
            mask_q     <= nmask;
            bright_q   <= nbright;
            digit_sel  <= nsel;
            an         <= (nstate == ON) ? ~(4'b0001 << nsel) : 4'hF;
            blank      <= (nstate != ON);
            frame_done <= nfd;
        end
    end

endmodule
`default_nettype wire
